dp_patgen: RTL and testbench

- Parametrised pixel-pattern source that stands in for the DMA pixel FIFO in front of the stuffer, for bring-up and loopback tests.
- Generalises the fixed two-pixel LCG test source in three ways: configurable pixels-per-word and pixel width, selectable pattern modes (LCG / ramp / colour bars / solid), and optional pseudo-random stall injection with underflow detection.
- Drives the stuffer's FIFO-side interface: data word, empty, read enable.

---
 rtl/dp_patgen_pkg.sv | 20 ++
 rtl/dp_lcg_chain.sv | 27 ++
 rtl/dp_patgen.sv | 135 +++++++++++++
 tb/tb_dp_patgen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_patgen_pkg.sv
// Shared definitions for the pixel-pattern source: pattern mode encodings
// and the stall LFSR seed, taps and step function.
package dp_patgen_pkg;

    typedef enum logic [1:0] {
        PAT_LCG   = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dp_lcg_chain.sv
// Combinational NPIX-step LCG: emits one pixel per step from the low bits of
// each state and returns the state after the last step (32-bit wrap).
module dp_lcg_chain #(
    parameter int unsigned PIXW = 24,
    parameter int unsigned NPIX = 2,
    parameter logic [31:0] LCGA = 32'd1664525,
    parameter logic [31:0] LCGC = 32'd1013904223
) (
    input  logic [31:0]           state,
    output logic [NPIX*PIXW-1:0]  word,
    output logic [31:0]           next_state
);

    logic [31:0] s;

    // Unrolled chain: pixel k takes s_k, then s_(k+1) = LCGA*s_k + LCGC.
    always_comb begin
        s    = state;
        word = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            word[k*PIXW +: PIXW] = PIXW'(s);
            s = s * LCGA + LCGC;
        end
        next_state = s;
    end

endmodule

// File: rtl/dp_patgen.sv
// Pixel-pattern source standing in for the DMA pixel FIFO in front of the
// stuffer. Presents a FIFO-style read interface (dout/empty/rden) with a
// priming window after start, optional pseudo-random stalls and a sticky
// underflow flag.
module dp_patgen
    import dp_patgen_pkg::*;
#(
    parameter int unsigned PIXW  = 24,
    parameter int unsigned NPIX  = 2,
    parameter logic [31:0] LCGA  = 32'd1664525,
    parameter logic [31:0] LCGC  = 32'd1013904223,
    parameter int unsigned PRIME = 4
) (
    input  logic                  dpclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rden,
    input  logic [1:0]            mode,
    input  logic [15:0]           hact,
    input  logic [PIXW-1:0]       solid,
    input  logic                  stallen,
    output logic [NPIX*PIXW-1:0]  dout,
    output logic                  empty,
    output logic                  underflow
);

    localparam int unsigned W   = NPIX * PIXW;
    localparam int unsigned CW  = PIXW / 3;
    localparam int unsigned PCW = $clog2(PRIME + 2);

    logic [31:0]    lcg_q;
    logic [31:0]    lcg_next;
    logic [W-1:0]   lcg_word;
    logic [15:0]    x_q;
    logic [15:0]    x_next;
    logic [16:0]    x_sum;
    logic [15:0]    hact_eff;
    logic [PCW-1:0] prime_q;
    logic [15:0]    lfsr_q;
    logic           stall_q;
    logic           rd;
    logic [W-1:0]   pat_word;
    logic [16:0]    pos;
    logic [2:0]     bar;
    logic [PIXW-1:0] pix;

    dp_lcg_chain #(
        .PIXW (PIXW),
        .NPIX (NPIX),
        .LCGA (LCGA),
        .LCGC (LCGC)
    ) u_lcg (
        .state      (lcg_q),
        .word       (lcg_word),
        .next_state (lcg_next)
    );

    assign hact_eff = (hact == 16'd0) ? 16'(NPIX) : hact;
    assign x_sum    = {1'b0, x_q} + 17'(NPIX);
    assign x_next   = (x_sum >= {1'b0, hact_eff}) ? '0 : x_sum[15:0];

    assign empty = (prime_q != '0) | stall_q;
    assign rd    = rden & ~empty & ~start;

    // Pattern word for the current position; the LCG chain and x advance on
    // every read regardless of mode, so only this selection depends on mode.
    always_comb begin
        pat_word = '0;
        pos      = '0;
        bar      = '0;
        pix      = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            pos = {1'b0, x_q} + 17'(k);
            bar = 3'({pos, 3'b000} / 20'(hact_eff));
            pix = '0;
            case (pat_mode_e'(mode))
                PAT_LCG:   pix = lcg_word[k*PIXW +: PIXW];
                PAT_RAMP:  begin
                    for (int unsigned i = 0; i < PIXW; i++) begin
                        pix[i] = pos[i % 16];
                    end
                end
                PAT_BARS:  begin
                    pix[2*CW +: CW] = {CW{bar[1]}};
                    pix[CW   +: CW] = {CW{bar[2]}};
                    pix[0    +: CW] = {CW{bar[0]}};
                end
                PAT_SOLID: pix = solid;
                default:   pix = '0;
            endcase
            pat_word[k*PIXW +: PIXW] = pix;
        end
    end

    // Frame state: start restarts the frame, reads advance it, reads while
    // empty only raise the sticky underflow flag.
    always_ff @(posedge dpclk or negedge reset) begin
        if (!reset) begin
            dout      <= '0;
            underflow <= 1'b0;
            lcg_q     <= '0;
            x_q       <= '0;
            prime_q   <= PCW'(PRIME);
        end else if (start) begin
            dout      <= '0;
            underflow <= 1'b0;
            lcg_q     <= '0;
            x_q       <= '0;
            prime_q   <= PCW'(PRIME);
        end else begin
            if (prime_q != '0) begin
                prime_q <= prime_q - 1'b1;
            end
            if (rd) begin
                dout  <= pat_word;
                lcg_q <= lcg_next;
                x_q   <= x_next;
            end else if (rden) begin
                underflow <= 1'b1;
            end
        end
    end

    // Stall generator: free-running LFSR, untouched by start.
    always_ff @(posedge dpclk or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= LFSR_SEED;
            stall_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_step(lfsr_q);
            stall_q <= stallen & (lfsr_q[2:0] == 3'b000);
        end
    end

endmodule

// File: tb/tb_dp_patgen.sv
// Scoreboard bench for dp_patgen: the stimulus process keeps an arithmetic
// reference model, predicts empty/underflow each cycle and queues the word
// every read should produce; a monitor pops and compares on each read.
module tb_dp_patgen;

    localparam int PIXW  = 24;
    localparam int NPIX  = 2;
    localparam int PRIME = 4;

    logic        dpclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rden = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] hact = 16'd640;
    logic [23:0] solid = 24'd0;
    logic        stallen = 1'b0;
    logic [47:0] dout;
    logic        empty;
    logic        underflow;

    // Requested configuration, applied to the DUT at the next driven edge.
    logic [1:0]  n_mode = 2'd0;
    logic [15:0] n_hact = 16'd640;
    logic [23:0] n_solid = 24'd0;
    logic        n_stallen = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [47:0] expq[$];

    // Reference model state
    logic [31:0] m_lcg;
    int          m_x;
    int          m_prime;
    logic [15:0] m_lfsr;
    bit          m_stall;
    bit          m_uf;

    dp_patgen #(
        .PIXW  (PIXW),
        .NPIX  (NPIX),
        .LCGA  (32'd1664525),
        .LCGC  (32'd1013904223),
        .PRIME (PRIME)
    ) dut (
        .dpclk     (dpclk),
        .reset     (reset),
        .start     (start),
        .rden      (rden),
        .mode      (mode),
        .hact      (hact),
        .solid     (solid),
        .stallen   (stallen),
        .dout      (dout),
        .empty     (empty),
        .underflow (underflow)
    );

    always #5 dpclk = ~dpclk;

    function automatic logic [31:0] lcg_adv(input logic [31:0] s);
        return s * 32'd1664525 + 32'd1013904223;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [23:0] model_pixel(input int md, input logic [31:0] lcg,
                                                input int k, input int x, input int he,
                                                input logic [23:0] sol);
        logic [31:0] s;
        logic [15:0] v;
        int b;
        case (md)
            0: begin
                s = lcg;
                for (int i = 0; i < k; i++) s = lcg_adv(s);
                return s[23:0];
            end
            1: begin
                v = 16'(x + k);
                return {v[7:0], v};
            end
            2: begin
                b = ((x + k) * 8) / he;
                return {((b & 2) != 0) ? 8'hFF : 8'h00,
                        ((b & 4) != 0) ? 8'hFF : 8'h00,
                        ((b & 1) != 0) ? 8'hFF : 8'h00};
            end
            default: return sol;
        endcase
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_init();
        m_lcg   = '0;
        m_x     = 0;
        m_prime = PRIME;
        m_lfsr  = 16'hACE1;
        m_stall = 1'b0;
        m_uf    = 1'b0;
    endtask

    function automatic bit model_empty();
        return (m_prime != 0) || m_stall;
    endfunction

    // One clock: check predicted flags, drive inputs for the coming edge and
    // advance the model across that edge.
    task automatic cycle(input bit st, input bit rd);
        bit me;
        int he;
        @(negedge dpclk);
        me = model_empty();
        chk("empty", 48'(empty), 48'(me));
        chk("underflow", 48'(underflow), 48'(m_uf));
        mode    = n_mode;
        hact    = n_hact;
        solid   = n_solid;
        stallen = n_stallen;
        start   = st;
        rden    = rd;
        he = (hact == 16'd0) ? NPIX : int'(hact);
        if (st) begin
            m_lcg   = '0;
            m_x     = 0;
            m_uf    = 1'b0;
            m_prime = PRIME;
        end else begin
            if (rd && !me) begin
                expq.push_back({model_pixel(int'(mode), m_lcg, 1, m_x, he, solid),
                                model_pixel(int'(mode), m_lcg, 0, m_x, he, solid)});
                m_lcg = lcg_adv(lcg_adv(m_lcg));
                m_x   = (m_x + NPIX >= he) ? 0 : m_x + NPIX;
            end else if (rd) begin
                m_uf = 1'b1;
            end
            if (m_prime != 0) m_prime--;
        end
        m_stall = stallen && (m_lfsr[2:0] == 3'b000);
        m_lfsr  = lfsr_adv(m_lfsr);
    endtask

    // Monitor: a read seen before an edge must yield the next queued word.
    initial begin
        bit fire;
        logic [47:0] e;
        forever begin
            @(negedge dpclk);
            #2;
            fire = reset && rden && !empty && !start;
            @(posedge dpclk);
            #1;
            if (fire) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected actual=%h required=none", dout);
                end else begin
                    e = expq.pop_front();
                    chk("word", dout, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bit rd;
        #1 reset = 1'b0;
        #3;
        chk("reset_dout", dout, 48'h0);
        chk("reset_empty", 48'(empty), 48'h1);
        chk("reset_underflow", 48'(underflow), 48'h0);
        @(posedge dpclk);
        #3 reset = 1'b1;
        model_init();

        // LCG: priming window then the two known first words
        n_mode = 2'd0;
        cycle(1, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0);
            if (empty) cnt++;
            else break;
        end
        chk("prime_cycles", 48'(cnt), 48'(PRIME));
        cycle(0, 1);
        @(posedge dpclk); #1;
        chk("lcg_first", dout, 48'h6EF35F_000000);
        cycle(0, 1);
        @(posedge dpclk); #1;
        chk("lcg_second_px0", 48'(dout[23:0]), 48'h502932);
        cycle(0, 0);

        // Ramp with wrap at hact=640
        n_mode = 2'd1;
        n_hact = 16'd640;
        cycle(1, 0);
        repeat (PRIME) cycle(0, 0);
        for (int n = 0; n < 330; n++) begin
            cycle(0, 1);
            @(posedge dpclk); #1;
            if (n == 0 || n == 319 || n == 320)
                chk("ramp_px0", 48'(dout[15:0]), 48'((2 * n) % 640));
        end

        // Colour bars
        n_mode = 2'd2;
        cycle(1, 0);
        repeat (PRIME) cycle(0, 0);
        for (int n = 0; n < 320; n++) begin
            cycle(0, 1);
            @(posedge dpclk); #1;
            if (n == 0 || n == 39)   chk("bars_0", 48'(dout[23:0]), 48'h000000);
            if (n == 40 || n == 79)  chk("bars_1", 48'(dout[23:0]), 48'h0000FF);
            if (n == 280 || n == 319) chk("bars_7", 48'(dout[23:0]), 48'hFFFFFF);
        end

        // Solid
        n_mode  = 2'd3;
        n_solid = 24'h123456;
        for (int n = 0; n < 4; n++) begin
            cycle(0, 1);
            @(posedge dpclk); #1;
            chk("solid", dout, {2{24'h123456}});
        end

        // Underflow during priming; a later start clears it
        cycle(1, 1);
        repeat (PRIME) cycle(0, 1);
        cycle(0, 0);
        chk("underflow_set", 48'(underflow), 48'h1);
        chk("underflow_dout_held", dout, 48'h0);
        cycle(1, 0);
        cycle(0, 0);
        chk("underflow_cleared", 48'(underflow), 48'h0);

        // Random stalls, modes and restarts with gated reads
        n_stallen = 1'b1;
        n_mode    = 2'd0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 7000) begin
                @(posedge dpclk);
                #3 reset = 1'b0;
                start = 1'b0;
                rden  = 1'b0;
                #1;
                chk("midreset_dout", dout, 48'h0);
                chk("midreset_empty", 48'(empty), 48'h1);
                chk("midreset_underflow", 48'(underflow), 48'h0);
                repeat (2) @(negedge dpclk);
                @(posedge dpclk);
                #3 reset = 1'b1;
                model_init();
            end
            if ($urandom_range(0, 49) == 0) n_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) n_solid = 24'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                case ($urandom_range(0, 3))
                    0: n_hact = 16'd0;
                    1: n_hact = 16'd8;
                    2: n_hact = 16'd640;
                    default: n_hact = 16'(2 * $urandom_range(1, 400));
                endcase
                cycle(1, 0);
            end else begin
                rd = !model_empty() && ($urandom_range(0, 7) != 0);
                cycle(0, rd);
            end
        end

        repeat (3) cycle(0, 0);
        chk("queue_drained", 48'(expq.size()), 48'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
